rr_arbiter_4: RTL and testbench

Four-requester round-robin arbiter with a registered grant. It shares the single 4:2 encoder-fed downstream resource between four agents. Grants are one-hot plus an encoded 2-bit index, so the consumer can drive the encoder path directly. Each grant is held while its requester keeps `req` asserted, up to a bounded burst length, and then rotates fairly.

---
 rtl/rr_arbiter_4.sv | 82 ++++++++
 tb/tb_rr_arbiter_4.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot + encoded grant.
// An owner keeps the grant while requesting, up to MAX_HOLD cycles when others wait.
module rr_arbiter_4 #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid
);

   localparam logic IDLE  = 1'b0;
   localparam logic GRANT = 1'b1;
   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

   logic       state;
   logic [1:0] ptr;
   logic [3:0] hold_cnt;

   logic [3:0] cand;
   logic       win_any;
   logic [1:0] win_idx;
   logic       do_grant, do_idle, do_inc;

   // ptr is always owner+1 while granting, so masking the owner bit gives
   // both the release search and the forced-rotation search.
   always_comb cand = (state == GRANT) ? (req & ~gnt) : req;

   always_comb begin
      win_any = 1'b0;
      win_idx = ptr;
      for (int k = 0; k < 4; k++) begin
         if (!win_any && cand[ptr + 2'(k)]) begin
            win_any = 1'b1;
            win_idx = ptr + 2'(k);
         end
      end
   end

   always_comb begin
      do_grant = 1'b0;
      do_idle  = 1'b0;
      do_inc   = 1'b0;
      if (state == IDLE) begin
         do_grant = win_any;
      end else if (!req[gnt_idx]) begin
         do_grant = win_any;
         do_idle  = !win_any;
      end else if (hold_cnt < HOLD_MAX) begin
         do_inc = 1'b1;
      end else begin
         do_grant = win_any;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         hold_cnt  <= 4'd0;
         gnt       <= 4'd0;
         gnt_idx   <= 2'd0;
         gnt_valid <= 1'b0;
      end else if (do_grant) begin
         state     <= GRANT;
         ptr       <= win_idx + 2'd1;
         hold_cnt  <= 4'd1;
         gnt       <= 4'b0001 << win_idx;
         gnt_idx   <= win_idx;
         gnt_valid <= 1'b1;
      end else if (do_idle) begin
         state     <= IDLE;
         gnt       <= 4'd0;
         gnt_valid <= 1'b0;
      end else if (do_inc) begin
         hold_cnt  <= hold_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_rr_arbiter_4;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;

   rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       vld;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   // reference model state
   bit m_vld;
   int m_own, m_ptr, m_hold;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int start, input int excl);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (start + k) % 4;
         if (j != excl && r[j]) return j;
      end
      return -1;
   endfunction

   task automatic m_grant(input int w);
      m_own = w; m_ptr = (w + 1) % 4; m_hold = 1; m_vld = 1;
   endtask

   task automatic model_reset();
      m_vld = 0; m_own = 0; m_ptr = 0; m_hold = 0;
   endtask

   task automatic model_step(input logic [3:0] r);
      int w;
      if (!m_vld) begin
         w = pick(r, m_ptr, -1);
         if (w >= 0) m_grant(w);
      end else if (!r[m_own]) begin
         w = pick(r, m_ptr, m_own);
         if (w >= 0) m_grant(w); else m_vld = 0;
      end else if (m_hold < MAX_HOLD) begin
         m_hold++;
      end else begin
         w = pick(r, m_own + 1, m_own);
         if (w >= 0) m_grant(w);
      end
   endtask

   task automatic step(input logic [3:0] r);
      exp_t e;
      req = r;
      model_step(r);
      e.gnt = m_vld ? (4'b0001 << m_own) : 4'b0000;
      e.idx = 2'(m_own);
      e.vld = m_vld;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 8'd0, 8'd1);
      end else begin
         e = sb.pop_front();
         chk("gnt", {4'd0, gnt}, {4'd0, e.gnt});
         chk("gnt_idx", {6'd0, gnt_idx}, {6'd0, e.idx});
         chk("gnt_valid", {7'd0, gnt_valid}, {7'd0, e.vld});
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_gnt"}, {4'd0, gnt}, 8'd0);
      chk({tag, "_idx"}, {6'd0, gnt_idx}, 8'd0);
      chk({tag, "_vld"}, {7'd0, gnt_valid}, 8'd0);
   endtask

   // Called just after a rising edge; reset is released before the next one.
   task automatic do_reset();
      req = 4'd0;
      rst_n = 1'b0;
      #2;
      chk_cleared("rst");
      rst_n = 1'b1;
      model_reset();
   endtask

   logic [3:0] r;

   initial begin
      model_reset();
      rst_n = 1'b0;
      req   = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk_cleared("reset_hold");
      end
      do_reset();

      // single requester, drop before edge 4
      step(4'b0100);
      chk("single_gnt", {4'd0, gnt}, 8'h04);
      step(4'b0100);
      step(4'b0100);
      step(4'b0000);
      chk("single_rel_vld", {7'd0, gnt_valid}, 8'd0);
      chk("single_rel_idx", {6'd0, gnt_idx}, 8'd2);

      // back-to-back handover
      @(posedge clk); #1;
      do_reset();
      step(4'b1010);
      chk("b2b_first", {4'd0, gnt}, 8'h02);
      step(4'b1000);
      chk("b2b_second", {4'd0, gnt}, 8'h08);
      chk("b2b_vld", {7'd0, gnt_valid}, 8'd1);

      // fair rotation, all requesting
      @(posedge clk); #1;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(4'b1111);
         chk("rot_idx", {6'd0, gnt_idx}, 8'((i / MAX_HOLD) % 4));
      end

      // sole owner saturation then a competitor
      @(posedge clk); #1;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(4'b0001);
         chk("sat_hold", {4'd0, gnt}, 8'h01);
      end
      step(4'b0101);
      chk("sat_rot", {4'd0, gnt}, 8'h04);

      // async reset mid-grant, checked between edges
      @(posedge clk); #1;
      do_reset();
      step(4'b1000);
      chk("mid_gnt", {4'd0, gnt}, 8'h08);
      #2;
      rst_n = 1'b0;
      #1;
      chk_cleared("mid_rst");
      #1;
      rst_n = 1'b1;
      model_reset();
      step(4'b1001);
      chk("mid_ptr0", {4'd0, gnt}, 8'h01);

      // random traffic against the model
      r = 4'd0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         step(r);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete at %0t", $time);
      $fatal(1);
   end

endmodule
